// File: rtl/rf_write_queue_if.sv
// ---------------------------------------------------------------------------
// rf_write_queue_if
// Bundles every non-clock signal of the register-file write queue.
//   Writeback side : in_valid, in_ready, in_reg, in_data
//   Drain control  : hold
//   Array side     : wr_en (one-hot), wr_data, count, empty
//   Bypass lookup  : rd_reg, rd_hit, rd_data
// Modports:
//   slave  - the queue itself
//   master - whoever drives requests and observes the array port
// ---------------------------------------------------------------------------
interface rf_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int NREG   = 16
);
    localparam int REG_W = $clog2(NREG);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_reg;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic [NREG-1:0]   wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic [REG_W-1:0]  rd_reg;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;

    modport slave (
        input  in_valid, in_reg, in_data, hold, rd_reg,
        output in_ready, wr_en, wr_data, count, empty, rd_hit, rd_data
    );

    modport master (
        output in_valid, in_reg, in_data, hold, rd_reg,
        input  in_ready, wr_en, wr_data, count, empty, rd_hit, rd_data
    );
endinterface

// File: rtl/rf_write_queue.sv
// ---------------------------------------------------------------------------
// rf_write_queue
// In-order FIFO of register writes sitting in front of the register array.
// Accepts {reg, data} requests from writeback via valid/ready and drains one
// entry per cycle onto a one-hot write-enable vector plus shared data bus.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset, discards all queued writes
//   q_if - rf_write_queue_if.slave (request, drain, array and bypass signals)
// Optional feature macro: RF_WRITE_QUEUE_BYPASS_EN
//   When defined, rd_hit/rd_data report the youngest pending write to rd_reg.
//   When undefined, rd_hit and rd_data are tied to 0 and rd_reg is ignored.
// ---------------------------------------------------------------------------
module rf_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int NREG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    rf_write_queue_if.slave  q_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int REG_W = $clog2(NREG);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage is never reset; only the pointers and count define validity.
    logic [REG_W-1:0]  regMem_q  [DEPTH];
    logic [DATA_W-1:0] dataMem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              notFull;
    logic              pushEn;
    logic              popEn;
    logic [REG_W-1:0]  headReg;
    logic [DATA_W-1:0] headData;

    // A full queue refuses pushes even if it pops this cycle (no pass-through).
    assign notFull  = (count_q != FULL_CNT);
    assign pushEn   = q_if.in_valid && notFull;
    assign popEn    = (count_q != '0) && !q_if.hold;
    assign headReg  = regMem_q[head_q];
    assign headData = dataMem_q[head_q];

    assign q_if.in_ready = notFull;
    assign q_if.count    = count_q;
    assign q_if.empty    = (count_q == '0);

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pushEn) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (popEn) begin
            head_d = head_q + PTR_W'(1);
        end
        if (pushEn && !popEn) begin
            count_d = count_q + CNT_W'(1);
        end else if (popEn && !pushEn) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            regMem_q[tail_q]  <= q_if.in_reg;
            dataMem_q[tail_q] <= q_if.in_data;
        end
    end

    // R0 entries still drain in order but never raise a write enable.
    always_comb begin
        q_if.wr_en   = '0;
        q_if.wr_data = '0;
        if (popEn) begin
            q_if.wr_data = headData;
            if (headReg != '0) begin
                q_if.wr_en[headReg] = 1'b1;
            end
        end
    end

`ifdef RF_WRITE_QUEUE_BYPASS_EN
    // Scan oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        q_if.rd_hit  = 1'b0;
        q_if.rd_data = '0;
        idx          = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + i[PTR_W-1:0];
            if ((i < int'(count_q)) && (q_if.rd_reg != '0) &&
                (regMem_q[idx] == q_if.rd_reg)) begin
                q_if.rd_hit  = 1'b1;
                q_if.rd_data = dataMem_q[idx];
            end
        end
    end
`else
    logic rdReg_unused;
    assign rdReg_unused = ^q_if.rd_reg;
    assign q_if.rd_hit  = 1'b0;
    assign q_if.rd_data = '0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// ---------------------------------------------------------------------------
// tb_rf_write_queue
// Directed and randomized stimulus for rf_write_queue, checked every cycle
// against a queue-based reference model of the write buffer.
// ---------------------------------------------------------------------------
module tb_rf_write_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int NREG   = 16;

    typedef struct {
        logic [3:0]  regIdx;
        logic [15:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    entry_t model[$];

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    rf_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NREG(NREG)) qIf();

    rf_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (qIf)
    );

    // One comparison: counts it, and on mismatch reports tag/observed/expected.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive inputs on the falling edge, then settle before anything is sampled.
    task automatic applyStimulus(input logic valid, input logic [3:0] regIdx,
                                 input logic [15:0] data, input logic hold,
                                 input logic [3:0] rdReg);
        @(negedge clk);
        qIf.in_valid = valid;
        qIf.in_reg   = regIdx;
        qIf.in_data  = data;
        qIf.hold     = hold;
        qIf.rd_reg   = rdReg;
        #1;
    endtask

    // Compare every output against what the queue model predicts right now.
    task automatic expectCycle();
        logic        pop;
        logic [15:0] expWrEn;
        logic [15:0] expWrData;
        logic        expHit;
        logic [15:0] expRdData;
        pop       = (model.size() > 0) && !qIf.hold;
        expWrEn   = '0;
        expWrData = '0;
        expHit    = 1'b0;
        expRdData = '0;
        if (pop) begin
            expWrData = model[0].data;
            if (model[0].regIdx != 4'd0) expWrEn = 16'(1) << model[0].regIdx;
        end
`ifdef RF_WRITE_QUEUE_BYPASS_EN
        foreach (model[i]) begin
            if (qIf.rd_reg != 4'd0 && model[i].regIdx == qIf.rd_reg) begin
                expHit    = 1'b1;
                expRdData = model[i].data;
            end
        end
`endif
        checkOutput("in_ready", 16'(qIf.in_ready), 16'(model.size() != DEPTH));
        checkOutput("wr_en",    qIf.wr_en,         expWrEn);
        checkOutput("wr_data",  qIf.wr_data,       expWrData);
        checkOutput("count",    16'(qIf.count),    16'(model.size()));
        checkOutput("empty",    16'(qIf.empty),    16'(model.size() == 0));
        checkOutput("rd_hit",   16'(qIf.rd_hit),   16'(expHit));
        checkOutput("rd_data",  qIf.rd_data,       expRdData);
    endtask

    // Advance one rising edge and apply the same push/pop rules to the model.
    task automatic tick();
        logic doPop;
        logic doPush;
        doPop  = (model.size() > 0) && !qIf.hold;
        doPush = qIf.in_valid && (model.size() < DEPTH);
        @(posedge clk);
        if (doPop) void'(model.pop_front());
        if (doPush) model.push_back('{qIf.in_reg, qIf.in_data});
    endtask

    task automatic runCycle(input logic valid, input logic [3:0] regIdx,
                            input logic [15:0] data, input logic hold,
                            input logic [3:0] rdReg);
        applyStimulus(valid, regIdx, data, hold, rdReg);
        expectCycle();
        tick();
    endtask

    // Whole test sequence: reset, directed scenarios, random traffic, summary.
    initial begin
        logic [15:0] drainOrder [4];
        drainOrder = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};

        rst          = 1'b1;
        qIf.in_valid = 1'b0;
        qIf.in_reg   = '0;
        qIf.in_data  = '0;
        qIf.hold     = 1'b0;
        qIf.rd_reg   = '0;

        // Reset state.
        applyStimulus(0, 0, 16'h0, 0, 0);
        expectCycle();
        @(negedge clk);
        rst = 1'b0;

        // Single push drains on the following cycle.
        runCycle(1, 4'd3, 16'hBEEF, 0, 0);
        applyStimulus(0, 0, 16'h0, 0, 0);
        expectCycle();
        checkOutput("t1_wr_en",   qIf.wr_en,   16'h0008);
        checkOutput("t1_wr_data", qIf.wr_data, 16'hBEEF);
        tick();
        applyStimulus(0, 0, 16'h0, 0, 0);
        checkOutput("t1_count", 16'(qIf.count), 16'd0);
        expectCycle();
        tick();

        // Fill under hold, refuse a fifth push, then drain in order.
        for (int k = 1; k <= 4; k++) runCycle(1, 4'(k), 16'(k * 16'h0101), 1, 0);
        applyStimulus(1, 4'd9, 16'hFFFF, 1, 0);
        expectCycle();
        checkOutput("t2_count",    16'(qIf.count),    16'd4);
        checkOutput("t2_in_ready", 16'(qIf.in_ready), 16'd0);
        checkOutput("t2_wr_en",    qIf.wr_en,         16'h0000);
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 16'h0, 0, 0);
            expectCycle();
            checkOutput($sformatf("t2_drain%0d", k), qIf.wr_en, drainOrder[k]);
            tick();
        end

        // Continuous push and drain across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 4'((k % 15) + 1), 16'($urandom), 0, 0);
            expectCycle();
            if (k > 0) checkOutput($sformatf("t3_count%0d", k), 16'(qIf.count), 16'd1);
            tick();
        end
        runCycle(0, 0, 16'h0, 0, 0);

        // R0 entry pops silently, the next one writes normally.
        runCycle(1, 4'd0, 16'h1234, 1, 0);
        runCycle(1, 4'd5, 16'h0055, 1, 0);
        applyStimulus(0, 0, 16'h0, 0, 0);
        expectCycle();
        checkOutput("t4_r0_wr_en", qIf.wr_en, 16'h0000);
        tick();
        applyStimulus(0, 0, 16'h0, 0, 0);
        expectCycle();
        checkOutput("t4_wr_en",   qIf.wr_en,   16'h0020);
        checkOutput("t4_wr_data", qIf.wr_data, 16'h0055);
        tick();

        // Bypass lookup picks the youngest matching write, never R0.
        runCycle(1, 4'd7, 16'hAAAA, 1, 0);
        runCycle(1, 4'd7, 16'hBBBB, 1, 0);
        applyStimulus(1, 4'd2, 16'hCCCC, 1, 4'd7);
        expectCycle();
`ifdef RF_WRITE_QUEUE_BYPASS_EN
        checkOutput("t6_rd_hit",  16'(qIf.rd_hit), 16'd1);
        checkOutput("t6_rd_data", qIf.rd_data,     16'hBBBB);
`else
        checkOutput("t6_rd_hit",  16'(qIf.rd_hit), 16'd0);
        checkOutput("t6_rd_data", qIf.rd_data,     16'h0000);
`endif
        tick();
        applyStimulus(0, 0, 16'h0, 1, 4'd0);
        expectCycle();
        checkOutput("t6_rd_hit_r0", 16'(qIf.rd_hit), 16'd0);

        // Reset with three entries queued discards them all.
        @(negedge clk);
        qIf.hold = 1'b0;
        rst      = 1'b1;
        #1;
        model.delete();
        checkOutput("t5_wr_en",    qIf.wr_en,         16'h0000);
        checkOutput("t5_count",    16'(qIf.count),    16'd0);
        checkOutput("t5_in_ready", 16'(qIf.in_ready), 16'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) runCycle(0, 0, 16'h0, 0, 4'd7);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            runCycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                     16'($urandom), ($urandom_range(0, 2) == 0),
                     4'($urandom_range(0, 15)));
        end
        for (int k = 0; k < DEPTH + 1; k++) runCycle(0, 0, 16'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
